uart_rx_fifo: RTL



---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_rx_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared defaults and status types for the UART receive path.
package uart_pkg;

    localparam int UART_WORD_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef struct packed {
        logic empty;
        logic full;
        logic overflow;
    } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int word_width = UART_WORD_WIDTH,
    parameter int depth      = UART_FIFO_DEPTH,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                  i_clk,
    input  logic                  i_wrEn,
    input  logic [addr_width-1:0] i_wrAddr,
    input  logic [word_width-1:0] i_wrData,
    input  logic [addr_width-1:0] i_rdAddr,
    output logic [word_width-1:0] o_rdData
);

    logic [word_width-1:0] r_mem [depth];

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO that captures each word completed by the UART receiver
// (falling edge of R_locked) and tracks fill level plus a sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int word_width = UART_WORD_WIDTH,
    parameter int depth      = UART_FIFO_DEPTH,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  R_locked,
    input  logic [word_width-1:0] R_W,
    input  logic                  pop,
    input  logic                  clear_ovf,
    output logic [word_width-1:0] D_OUT,
    output logic                  empty,
    output logic                  full,
    output logic [addr_width:0]   count,
    output logic                  overflow
);

    localparam logic [addr_width:0]   CNT_FULL = (addr_width+1)'(depth);
    localparam logic [addr_width:0]   CNT_ONE  = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] PTR_ONE  = addr_width'(1);

    logic                  r_lockQ;
    logic [addr_width-1:0] r_wrPtr;
    logic [addr_width-1:0] r_rdPtr;
    logic [addr_width:0]   r_count;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_doPop;
    logic                  w_doPush;
    logic                  w_drop;
    logic [word_width-1:0] w_rdData;

    assign w_push  = r_lockQ & ~R_locked;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_doPop = pop & ~w_empty;
    // A pop on a full FIFO frees the slot, so the simultaneous push is accepted.
    assign w_doPush = w_push & (~w_full | w_doPop);
    assign w_drop   = w_push & w_full & ~w_doPop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lockQ    <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_lockQ <= R_locked;
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as clear_ovf keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .word_width(word_width),
        .depth     (depth)
    ) u_mem (
        .i_clk   (clk),
        .i_wrEn  (w_doPush),
        .i_wrAddr(r_wrPtr),
        .i_wrData(R_W),
        .i_rdAddr(r_rdPtr),
        .o_rdData(w_rdData)
    );

    assign D_OUT    = w_empty ? '0 : w_rdData;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
